rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of requesters; only 8 is supported.
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum number of consecutive grant cycles per owner when others wait; legal range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 8 bits, the request vector with bit i for requester i, level-sensitive.
REQ-006 The block SHALL have port gnt, output, 8 bits, the one-hot grant vector, all zero when no grant.
REQ-007 The block SHALL have port gnt_id, output, 3 bits, the binary index of the current owner.
REQ-008 The block SHALL have port gnt_valid, output, 1 bit, high while a grant is held.

Function
REQ-009 All outputs SHALL be registered; gnt, gnt_id and gnt_valid SHALL always be mutually consistent (gnt == 1<<gnt_id when gnt_valid, gnt == 0 otherwise).
REQ-010 The FSM SHALL have two states, IDLE (no owner) and GRANT (owner held).
REQ-011 A round-robin pointer ptr (3 bits) SHALL define priority: the first set req bit scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1 wins.
REQ-012 In IDLE with req != 0 at edge k, the winner SHALL be granted, state GRANT, with outputs visible after edge k (1-cycle latency); with req == 0, the FSM SHALL stay in IDLE.
REQ-013 In GRANT, the grant SHALL be held while req[owner] == 1 and hold_cnt < MAX_HOLD-1; hold_cnt SHALL increment each held cycle.
REQ-014 Release: at the edge where req[owner] == 0, ptr SHALL become (owner+1) mod 8; the winner among the remaining req bits (owner excluded) SHALL be granted at the same edge with no dead cycle; if none, state SHALL go IDLE with gnt = 0.
REQ-015 Timeout: at the edge where hold_cnt == MAX_HOLD-1 and another req bit is set, the owner SHALL be revoked and the next winner granted per REQ-014, even though req[owner] is still 1.
REQ-016 At timeout with no other requester, the owner SHALL keep the grant and hold_cnt SHALL restart at 0.
REQ-017 hold_cnt SHALL reset to 0 on every new grant; ptr wrap-around from 7 SHALL go to 0.
REQ-018 Requests rising while another owner is held SHALL NOT affect gnt until release or timeout.
REQ-019 Simultaneous release of the owner and assertion of new requests at the same edge SHALL be arbitrated using that edge's req value.

Reset
REQ-020 While rst_n == 0: state = IDLE, ptr = 0, hold_cnt = 0, gnt = 8'h00, gnt_id = 0, gnt_valid = 0, taking effect immediately without a clock.
REQ-021 Reset asserted mid-grant SHALL drop the grant asynchronously; after deassertion, arbitration SHALL restart from ptr = 0.

Structure
REQ-022 Package arb_pkg SHALL hold the N constant, the state enum (IDLE, GRANT) and the MAX_HOLD default.
REQ-023 The masked first-set search SHALL be a combinational sub-module prio_enc8 (8-bit in, {valid, 3-bit index} out), instantiated twice (masked at/after ptr, and unmasked) for wrap-around selection.

Verification
REQ-024 Reset then req = 8'b00000000 for 5 cycles -> gnt = 0, gnt_valid = 0 throughout.
REQ-025 req = 8'b10000001 from reset -> gnt = 8'b00000001, gnt_id = 0 one cycle later; drop req[0] -> next edge gnt = 8'b10000000, gnt_id = 7 with no gap.
REQ-026 All req = 8'hFF, each owner drops its bit after 1 grant cycle and reasserts -> gnt_id sequence 0,1,2,...,7,0 (wrap).
REQ-027 req = 8'b00000110 held constant with MAX_HOLD = 4 -> owner 1 held exactly 4 cycles, then owner 2 for 4 cycles, then owner 1 again.
REQ-028 req = 8'b00100000 held alone for 40 cycles with MAX_HOLD = 16 -> gnt_id = 5 continuously, never deasserted.
REQ-029 rst_n pulsed low mid-grant of owner 6 -> gnt = 0 before the next clk edge; after release with req = 8'b01000100 -> gnt_id = 2.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the round-robin arbiter
package arb_pkg;

  localparam int N_REQ            = 8;
  localparam int MAX_HOLD_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - 8-bit lowest-index-first priority encoder
module prio_enc8 (
  input  logic [7:0] in_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = 3'd0;
    valid_o = |in_i;
    for (int i = 7; i >= 0; i--) begin
      if (in_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold-time limit
import arb_pkg::*;

module rr_arbiter8 #(
  parameter int N        = N_REQ,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [2:0]   gnt_id,
  output logic         gnt_valid
);

  arb_state_e   state_q, state_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [7:0]   hold_q, hold_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [2:0]   id_q, id_d;
  logic         valid_q, valid_d;

  logic [N-1:0] owner_mask;
  logic [N-1:0] cand;
  logic [N-1:0] cand_hi;
  logic [2:0]   base;
  logic         hi_valid, all_valid;
  logic [2:0]   hi_idx, all_idx;
  logic         win_valid;
  logic [2:0]   win_id;
  logic         release_c, timeout_c;

  // Candidate set excludes the current owner; the scan starts just past the
  // owner while granted, or at the stored pointer while idle.
  always_comb begin
    owner_mask = (state_q == GRANT) ? (N'(1) << id_q) : '0;
    cand       = req & ~owner_mask;
    base       = (state_q == GRANT) ? 3'(id_q + 3'd1) : ptr_q;
    cand_hi    = cand & (N'({N{1'b1}}) << base);
  end

  prio_enc8 u_enc_hi (
    .in_i    (cand_hi),
    .valid_o (hi_valid),
    .idx_o   (hi_idx)
  );

  prio_enc8 u_enc_all (
    .in_i    (cand),
    .valid_o (all_valid),
    .idx_o   (all_idx)
  );

  // Prefer requesters at/after the scan base, wrapping to the lowest index.
  always_comb begin
    win_valid = all_valid;
    win_id    = hi_valid ? hi_idx : all_idx;
    release_c = (state_q == GRANT) && !req[id_q];
    timeout_c = (state_q == GRANT) && (hold_q == 8'(MAX_HOLD - 1));
  end

  // Next-state: grant from idle, hold, release or timeout hand-over.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = GRANT;
          id_d    = win_id;
          gnt_d   = N'(1) << win_id;
          valid_d = 1'b1;
          hold_d  = 8'd0;
        end
      end
      GRANT: begin
        if (release_c || (timeout_c && win_valid)) begin
          ptr_d = 3'(id_q + 3'd1);
          if (win_valid) begin
            id_d    = win_id;
            gnt_d   = N'(1) << win_id;
            valid_d = 1'b1;
            hold_d  = 8'd0;
          end else begin
            state_d = IDLE;
            id_d    = 3'd0;
            gnt_d   = '0;
            valid_d = 1'b0;
            hold_d  = 8'd0;
          end
        end else if (timeout_c) begin
          hold_d = 8'd0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = 3'd0;
        valid_d = 1'b0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      hold_q  <= 8'd0;
      gnt_q   <= '0;
      id_q    <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed table-driven bench for rr_arbiter8
module tb_rr_arbiter8;

  typedef struct {
    logic [7:0] req;
    logic [2:0] id;
    logic       valid;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt, gnt4;
  logic [2:0] gnt_id, id4;
  logic       gnt_valid, v4;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  rr_arbiter8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  rr_arbiter8 #(.N(8), .MAX_HOLD(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt4),
    .gnt_id    (id4),
    .gnt_valid (v4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] g, input logic [2:0] id,
                       input logic v, input logic [2:0] eid, input logic ev);
    logic [7:0] eg;
    eg = ev ? (8'h01 << eid) : 8'h00;
    checks++;
    if (g !== eg || v !== ev || (ev && id !== eid)) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b, want gnt=%b id=%0d valid=%b",
               name, g, id, v, eg, eid, ev);
    end
  endtask

  task automatic step(input logic [7:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    req   = r;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    // reset state
    #2;
    check("reset", gnt, gnt_id, gnt_valid, 3'd0, 1'b0);
    check("reset_mh4", gnt4, id4, v4, 3'd0, 1'b0);
    checks++;
    if (gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_id: got %0d want 0", gnt_id);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) vecs.push_back('{8'h00, 3'd0, 1'b0});
    vecs.push_back('{8'h81, 3'd0, 1'b1});
    vecs.push_back('{8'h80, 3'd7, 1'b1});
    vecs.push_back('{8'h00, 3'd0, 1'b0});
    vecs.push_back('{8'hFF, 3'd0, 1'b1});
    vecs.push_back('{8'hFE, 3'd1, 1'b1});
    vecs.push_back('{8'hFD, 3'd2, 1'b1});
    vecs.push_back('{8'hFB, 3'd3, 1'b1});
    vecs.push_back('{8'hF7, 3'd4, 1'b1});
    vecs.push_back('{8'hEF, 3'd5, 1'b1});
    vecs.push_back('{8'hDF, 3'd6, 1'b1});
    vecs.push_back('{8'hBF, 3'd7, 1'b1});
    vecs.push_back('{8'h7F, 3'd0, 1'b1});
    vecs.push_back('{8'h00, 3'd0, 1'b0});
    // idle ptr=1 now: lone requester 5 holds through timeouts
    for (int i = 0; i < 40; i++) vecs.push_back('{8'h20, 3'd5, 1'b1});
    vecs.push_back('{8'h00, 3'd0, 1'b0});
    // idle ptr=6: wrap to 0, late request ignored, release + new request same edge
    vecs.push_back('{8'h01, 3'd0, 1'b1});
    vecs.push_back('{8'h03, 3'd0, 1'b1});
    vecs.push_back('{8'h02, 3'd1, 1'b1});
    vecs.push_back('{8'h05, 3'd2, 1'b1});
    vecs.push_back('{8'h00, 3'd0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step(v.req);
      check($sformatf("vec%0d", i), gnt, gnt_id, gnt_valid, v.id, v.valid);
      check($sformatf("vec%0d_mh4", i), gnt4, id4, v4, v.id, v.valid);
    end

    // timeout rotation between requesters 1 and 2 with MAX_HOLD=4
    do_reset(8'h06);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("tmo%0d_mh4", i), gnt4, id4, v4, (i >= 4 && i < 8) ? 3'd2 : 3'd1, 1'b1);
      check($sformatf("tmo%0d", i), gnt, gnt_id, gnt_valid, 3'd1, 1'b1);
    end

    // asynchronous reset mid-grant of owner 6
    do_reset(8'h00);
    step(8'h40);
    check("own6", gnt, gnt_id, gnt_valid, 3'd6, 1'b1);
    step(8'h40);
    check("own6_hold", gnt, gnt_id, gnt_valid, 3'd6, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", gnt, gnt_id, gnt_valid, 3'd0, 1'b0);
    check("async_rst_mh4", gnt4, id4, v4, 3'd0, 1'b0);
    req = 8'h44;
    @(posedge clk);
    #1;
    check("rst_held", gnt, gnt_id, gnt_valid, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_rst", gnt, gnt_id, gnt_valid, 3'd2, 1'b1);
    check("after_rst_mh4", gnt4, id4, v4, 3'd2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
